// File: rtl/inst_fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction memory port, redirect/halt controls
// and the decode-facing valid/ready stream.
interface inst_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] i_mem_inst;
  logic              i_redirect;
  logic [ADDR_W-1:0] i_redirect_pc;
  logic              i_halt;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_inst;
  logic [ADDR_W-1:0] o_pc;
  logic              o_halted;

  // Fetch controller side: drives the memory address and the decode stream
  modport master (
    output o_mem_addr,
    output o_valid,
    output o_inst,
    output o_pc,
    output o_halted,
    input  i_mem_inst,
    input  i_redirect,
    input  i_redirect_pc,
    input  i_halt,
    input  i_ready
  );

  // Environment side: memory, branch unit and decode
  modport slave (
    input  o_mem_addr,
    input  o_valid,
    input  o_inst,
    input  o_pc,
    input  o_halted,
    output i_mem_inst,
    output i_redirect,
    output i_redirect_pc,
    output i_halt,
    output i_ready
  );

endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues word addresses to a
// one-cycle-latency instruction memory, buffers returned words in a 2-entry
// queue and streams them to decode. Handles branch redirect and halt.
module inst_fetch_ctrl #(
  parameter int unsigned          ADDR_W   = 12,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  inst_fetch_ctrl_if.master bus
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_v_q, inflight_v_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  entry_t            ent0_q, ent0_d;
  entry_t            ent1_q, ent1_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  logic              pop_c;
  logic              push_c;
  logic              credit_c;
  logic              issue_c;
  logic [OCC_W-1:0]  occ_c;
  entry_t            new_ent_c;

  // Handshake, capture and queue-credit terms shared by FSM and datapath
  always_comb begin
    pop_c     = valid_q & bus.i_ready;
    push_c    = inflight_v_q;
    new_ent_c = '{pc: inflight_pc_q, inst: bus.i_mem_inst};
    occ_c     = OCC_W'(count_q) + OCC_W'(inflight_v_q);
    credit_c  = (occ_c - OCC_W'(pop_c)) < OCC_W'(2);
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: halt parks the sequencer, redirect or halt release resumes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (bus.i_halt && !bus.i_redirect) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (!bus.i_halt || bus.i_redirect) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // FSM output: issue a fetch only while running, not halted/redirected, with queue room
  always_comb begin
    issue_c = 1'b0;
    case (state_q)
      S_RUN:   issue_c = !bus.i_halt && !bus.i_redirect && credit_c;
      S_HALT:  issue_c = 1'b0;
      default: issue_c = 1'b0;
    endcase
  end

  // Datapath next-state: PC advance, in-flight tag and 2-entry queue
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_v_d  = inflight_v_q;
    inflight_pc_d = inflight_pc_q;
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    count_d       = count_q;

    if (bus.i_redirect) begin
      // Flush everything, including any transfer in this cycle
      fetch_pc_d   = bus.i_redirect_pc;
      inflight_v_d = 1'b0;
      ent0_d       = '0;
      ent1_d       = '0;
      count_d      = '0;
    end else begin
      inflight_v_d = issue_c;
      if (issue_c) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
      end

      // Head is kept at zero whenever the queue is empty
      case (count_q)
        CNT_W'(0): begin
          if (push_c) begin
            ent0_d  = new_ent_c;
            count_d = CNT_W'(1);
          end
        end
        CNT_W'(1): begin
          if (push_c && pop_c) begin
            ent0_d = new_ent_c;
          end else if (push_c) begin
            ent1_d  = new_ent_c;
            count_d = CNT_W'(2);
          end else if (pop_c) begin
            ent0_d  = '0;
            count_d = CNT_W'(0);
          end
        end
        CNT_W'(2): begin
          if (pop_c) begin
            ent0_d = ent1_q;
            if (push_c) begin
              ent1_d = new_ent_c;
            end else begin
              ent1_d  = '0;
              count_d = CNT_W'(1);
            end
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end

    valid_d  = (count_d != '0);
    halted_d = (state_d == S_HALT) && (count_d == '0) && !inflight_v_d;
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
      ent0_q        <= '0;
      ent1_q        <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
      ent0_q        <= ent0_d;
      ent1_q        <= ent1_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.o_mem_addr = fetch_pc_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_inst     = ent0_q.inst;
  assign bus.o_pc       = ent0_q.pc;
  assign bus.o_halted   = halted_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: startup latency, backpressure, redirect,
// PC wrap, halt/resume and mid-stream reset, against a mem[k]=k+0x100 memory.
module tb_inst_fetch_ctrl;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_xfer = 0;
  logic [ADDR_W-1:0] exp_pc;
  logic [ADDR_W-1:0] saved_addr;
  logic [15:0]       lfsr;

  always #5 clk = ~clk;

  inst_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  inst_fetch_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(12'h000)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  // Synchronous instruction memory: word k holds k + 0x100
  always @(posedge clk) begin
    bus.i_mem_inst <= DATA_W'(bus.o_mem_addr) + 32'h100;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Score a transfer happening at the coming edge, then advance one cycle
  task automatic tick();
    if (bus.o_valid && bus.i_ready && !bus.i_redirect) begin
      check_eq("xfer_pc", 32'(bus.o_pc), 32'(exp_pc));
      check_eq("xfer_inst", bus.o_inst, 32'(exp_pc) + 32'h100);
      exp_pc = exp_pc + 12'd1;
      n_xfer++;
    end
    step();
  endtask

  // Entered just after an edge with reset asserted; releases reset and checks C0..C2 and streaming
  task automatic startup();
    check_eq("rst_valid",  32'(bus.o_valid),    32'd0);
    check_eq("rst_pc",     32'(bus.o_pc),       32'd0);
    check_eq("rst_inst",   bus.o_inst,          32'd0);
    check_eq("rst_halted", 32'(bus.o_halted),   32'd0);
    check_eq("rst_addr",   32'(bus.o_mem_addr), 32'd0);
    rst = 1'b0;
    bus.i_ready = 1'b1;
    check_eq("c0_valid", 32'(bus.o_valid), 32'd0);
    step();
    check_eq("c1_valid", 32'(bus.o_valid),    32'd0);
    check_eq("c1_addr",  32'(bus.o_mem_addr), 32'd1);
    step();
    check_eq("c2_valid", 32'(bus.o_valid), 32'd1);
    check_eq("c2_pc",    32'(bus.o_pc),    32'd0);
    check_eq("c2_inst",  bus.o_inst,       32'h100);
    exp_pc = '0;
    for (int i = 0; i < 5; i++) begin
      check_eq("stream_valid", 32'(bus.o_valid), 32'd1);
      tick();
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_halt        = 1'b0;
    bus.i_ready       = 1'b1;
    exp_pc            = '0;
    lfsr              = 16'hACE1;
    repeat (3) step();

    // Startup from reset
    startup();

    // Pseudo-random backpressure: accepted PCs must stay strictly sequential
    n_xfer = 0;
    for (int i = 0; i < 200; i++) begin
      bus.i_ready = lfsr[0];
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      tick();
    end
    check_eq("rand_progress", 32'(n_xfer >= 60), 32'd1);

    // Fill the queue, then redirect to 0x7F0 with a void transfer in the redirect cycle
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("full_valid", 32'(bus.o_valid), 32'd1);
    check_eq("full_head",  32'(bus.o_pc),    32'(exp_pc));
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 12'h7F0;
    bus.i_ready       = 1'b1;
    step();
    bus.i_redirect = 1'b0;
    check_eq("r1_valid", 32'(bus.o_valid),    32'd0);
    check_eq("r1_addr",  32'(bus.o_mem_addr), 32'h7F0);
    step();
    check_eq("r2_valid", 32'(bus.o_valid), 32'd0);
    step();
    check_eq("r3_valid", 32'(bus.o_valid), 32'd1);
    check_eq("r3_pc",    32'(bus.o_pc),    32'h7F0);
    exp_pc = 12'h7F0;
    for (int i = 0; i < 3; i++) tick();

    // Address wrap 0xFFE -> 0x001
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 12'hFFE;
    step();
    bus.i_redirect = 1'b0;
    step();
    step();
    exp_pc = 12'hFFE;
    for (int i = 0; i < 4; i++) begin
      check_eq("wrap_valid", 32'(bus.o_valid), 32'd1);
      tick();
    end
    check_eq("wrap_next", 32'(exp_pc), 32'h002);
    tick();
    tick();

    // Halt for 10 cycles: drain only, no address movement, then resume without gaps
    n_xfer     = 0;
    bus.i_halt = 1'b1;
    saved_addr = bus.o_mem_addr;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        check_eq("halt_early", 32'(bus.o_halted),   32'd0);
        check_eq("halt_addr1", 32'(bus.o_mem_addr), 32'(saved_addr));
      end
      tick();
    end
    check_eq("halt_xfers",  32'(n_xfer <= 2),     32'd1);
    check_eq("halt_halted", 32'(bus.o_halted),    32'd1);
    check_eq("halt_valid",  32'(bus.o_valid),     32'd0);
    check_eq("halt_addr",   32'(bus.o_mem_addr),  32'(saved_addr));
    bus.i_halt = 1'b0;
    for (int i = 0; i < 8 && !bus.o_valid; i++) step();
    check_eq("resume_valid", 32'(bus.o_valid), 32'd1);
    tick();
    tick();

    // Redirect together with halt: target loaded, no issue while halt stays high
    bus.i_halt        = 1'b1;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 12'h123;
    step();
    bus.i_redirect = 1'b0;
    step();
    step();
    step();
    check_eq("rh_valid",  32'(bus.o_valid),    32'd0);
    check_eq("rh_addr",   32'(bus.o_mem_addr), 32'h123);
    check_eq("rh_halted", 32'(bus.o_halted),   32'd1);
    bus.i_halt = 1'b0;
    exp_pc     = 12'h123;
    for (int i = 0; i < 8 && !bus.o_valid; i++) step();
    check_eq("rh_resume", 32'(bus.o_valid), 32'd1);
    tick();
    tick();

    // Reset mid-stream with a full queue, then a clean restart
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("pre_rst_valid", 32'(bus.o_valid), 32'd1);
    rst = 1'b1;
    step();
    startup();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch sequencer for the FDE CPU. It owns the program counter and drives the word address of the synchronous instruction memory, which returns data one cycle after the address. It buffers returned words in a 2-entry queue and presents them to decode over a valid/ready handshake. It also handles branch redirect (flush) and halt.

## Interface
- ADDR_W, 12: instruction memory word-address width; PC width.
- DATA_W, 32: instruction width.
- RESET_PC, 0: PC loaded on reset.

Ports:
- i_clk  in  1  sole clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- o_mem_addr  out  ADDR_W  word address to instruction memory; equals the fetch PC register.
- i_mem_inst  in  DATA_W  instruction memory read data; the word for the address presented in the previous cycle.
- i_redirect  in  1  branch/jump redirect; one-cycle pulse.
- i_redirect_pc  in  ADDR_W  target word address, valid with i_redirect.
- i_halt  in  1  level; when high, no new fetches are issued.
- o_valid  out  1  o_inst/o_pc hold a fetched instruction.
- i_ready  in  1  decode accepts; transfer = o_valid & i_ready.
- o_inst  out  DATA_W  head-of-queue instruction.
- o_pc  out  ADDR_W  word address of o_inst.
- o_halted  out  1  FSM is in S_HALT and queue and in-flight are empty.

## Operation
- Registers:
  - fetch_pc
  - inflight_v / inflight_pc, tagging the address issued last cycle
  - 2-entry FIFO of {pc, inst}, with count 0..2
  - FSM state
- FSM states:
  - S_RUN: issuing allowed.
  - S_HALT: no issue.
  - S_RUN→S_HALT when i_halt=1 and i_redirect=0.
  - S_HALT→S_RUN when i_halt=0 or i_redirect=1.
- Issue condition, combinational: state==S_RUN, i_halt=0, i_redirect=0, and (count + inflight_v − pop) < 2, where pop = o_valid & i_ready.
- On issue: inflight_v<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1, modulo 2^ADDR_W (4095→0). Otherwise inflight_v<=0 and fetch_pc holds.
- Capture: when inflight_v=1, {inflight_pc, i_mem_inst} is pushed into the FIFO this cycle.
- Credit rule guarantees push never targets a full FIFO. Push and pop in the same cycle leaves count unchanged.
- o_valid = (count>0). o_inst/o_pc come from the FIFO head register, which is 0 when empty.
- Redirect has top priority:
  - FIFO count<=0, inflight_v<=0, fetch_pc<=i_redirect_pc. No issue that cycle.
  - A transfer in the redirect cycle is void; decode discards it.
- Halt: issue stops; the in-flight word and buffered words still drain to decode normally. Clearing i_halt resumes from fetch_pc with no skipped or duplicated PC.
- Reset (any cycle, including mid-stream): fetch_pc=RESET_PC, inflight_v=0, count=0, state=S_RUN. o_valid=0, o_inst=0, o_pc=0, o_halted=0, o_mem_addr=RESET_PC. Memory output during reset is ignored.

## Timing
- Cycle C0 = first cycle with i_reset=0:
  - C0: issue of RESET_PC.
  - C1: capture.
  - C2: o_valid=1, o_pc=RESET_PC.
- Fetch-to-valid latency is 2 cycles. Sustained throughput is 1 instruction/cycle with i_ready held high (steady state count=1, inflight=1).
- Redirect sampled at cycle R: o_valid=0 in R+1; target issued in R+1; o_valid=1 with o_pc=target in R+3.
- i_ready low: at most 2 words accumulate; issue stalls; no word lost or duplicated. Resuming i_ready gives back-to-back transfers.
- i_halt sampled high in cycle H: last issue is in H−1. o_halted rises once the queue drains, no earlier than H+2.
- Simultaneous redirect+halt: redirect applied, FSM goes to S_RUN but issue blocked while i_halt=1.
- o_mem_addr changes only on clock edges.

## Test plan
- Reset release, memory preloaded mem[k]=k+0x100, i_ready=1 → o_valid rises at C2; o_pc=0,1,2,... and o_inst=0x100,0x101,... on consecutive cycles.
- i_ready toggled 1,0,0,1,0,1 pseudo-randomly over 200 cycles → accepted o_pc sequence strictly +1, no gaps or repeats; count never exceeds 2.
- Redirect to 0x7F0 while 2 words are buffered → next accepted o_pc=0x7F0 exactly 3 cycles after the redirect; old words never accepted.
- fetch_pc at 0xFFE, free-running → o_pc sequence 0xFFE, 0xFFF, 0x000, 0x001.
- i_halt high for 10 cycles with i_ready=1 → at most 2 further transfers, o_halted=1, o_mem_addr stable; after release the next o_pc follows the last accepted o_pc +1.
- i_reset asserted mid-stream with FIFO full → next cycle o_valid=0, o_pc=0, o_mem_addr=RESET_PC; restart matches the first scenario.
